// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port data_mem between core load/store path and a host port
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_halted,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_stall,
  output logic [DW-1:0] core_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_lock,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stall_ct
);
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic {S_CORE, S_HOST} own_t;
  own_t          own_q, own_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [15:0]   stall_q, stall_d;
  logic          core_g, host_g;
  // grant decision: halted core yields, burst owner and starved host win, else core first
  always_comb begin
    core_g = 1'b0;
    host_g = 1'b0;
    if (!reset) begin
      if (core_halted) host_g = host_req;
      else if (host_req && (own_q == S_HOST || wait_q == WW'(STARVE_LIMIT))) host_g = 1'b1;
      else if (core_req) core_g = 1'b1;
      else host_g = host_req;
    end
  end
  assign host_gnt   = host_g;
  assign core_stall = core_req & ~core_halted & ~core_g & ~reset;
  assign mem_addr   = host_g ? host_addr : core_g ? core_addr : '0;
  assign mem_wdata  = host_g ? host_wdata : core_g ? core_wdata : '0;
  assign mem_read   = (host_g & ~host_we) | (core_g & ~core_we);
  assign mem_write  = (host_g & host_we) | (core_g & core_we);
  assign core_rdata = (core_g & ~core_we) ? mem_rdata : '0;
  assign host_rdata = (host_g & ~host_we) ? mem_rdata : '0;
  assign stall_ct   = reset ? 16'd0 : stall_q;
  // next state: starvation counter, burst ownership, saturating stall counter
  always_comb begin
    own_d   = own_q;
    burst_d = burst_q;
    wait_d  = (host_req & ~host_g) ? ((wait_q == WW'(STARVE_LIMIT)) ? wait_q : wait_q + WW'(1)) : '0;
    stall_d = (core_stall && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    if (own_q == S_CORE) begin
      if (host_g && host_lock && MAX_BURST > 1) begin
        own_d   = S_HOST;
        burst_d = BW'(1);
      end
    end else if (host_g && host_lock && burst_q < BW'(MAX_BURST - 1)) begin
      burst_d = burst_q + BW'(1);
    end else begin
      own_d   = S_CORE;
      burst_d = '0;
      wait_d  = '0;
    end
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      own_q   <= S_CORE;
      wait_q  <= '0;
      burst_q <= '0;
      stall_q <= '0;
    end else begin
      own_q   <= own_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed checks of dmem_arbiter against a reference model
module tb_dmem_arbiter;
  localparam int SL = 4;
  localparam int MB = 8;
  logic clk = 1'b0;
  logic reset = 1'b1, core_halted = 1'b0, core_req = 1'b0, core_we = 1'b0;
  logic host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
  logic [7:0] core_addr = '0, core_wdata = '0, host_addr = '0, host_wdata = '0;
  logic core_stall, host_gnt, mem_read, mem_write;
  logic [7:0] core_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] stall_ct;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int checks = 0, errors = 0;
  int hwait = 0, burst_left = 0, stalls = 0;
  logic last_hg, last_stall;
  logic [7:0] last_hrd;

  dmem_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(SL), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .core_halted(core_halted), .core_req(core_req),
    .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rdata(core_rdata), .host_req(host_req),
    .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_ct(stall_ct)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic hlt, input logic cr, input logic cw,
                      input logic [7:0] ca, input logic [7:0] cd, input logic hr, input logic hw,
                      input logic hl, input logic [7:0] ha, input logic [7:0] hd);
    logic eh, ec, es;
    logic [7:0] ea;
    reset = rst; core_halted = hlt; core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    host_req = hr; host_we = hw; host_lock = hl; host_addr = ha; host_wdata = hd;
    #1;
    eh = 1'b0;
    ec = 1'b0;
    if (!rst) begin
      if (hlt) eh = hr;
      else if (hr && (burst_left > 0 || hwait >= SL)) eh = 1'b1;
      else if (cr) ec = 1'b1;
      else eh = hr;
    end
    es = !rst && cr && !hlt && !ec;
    ea = eh ? ha : ec ? ca : 8'h00;
    chk("host_gnt", host_gnt, eh);
    chk("core_stall", core_stall, es);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, eh ? hd : ec ? cd : 8'h00);
    chk("mem_write", mem_write, (eh && hw) || (ec && cw));
    chk("mem_read", mem_read, (eh && !hw) || (ec && !cw));
    chk("core_rdata", core_rdata, (ec && !cw) ? ref_mem[ca] : 8'h00);
    chk("host_rdata", host_rdata, (eh && !hw) ? ref_mem[ha] : 8'h00);
    chk("stall_ct", stall_ct, rst ? 0 : stalls);
    last_hg = host_gnt;
    last_stall = core_stall;
    last_hrd = host_rdata;
    if (rst) begin
      hwait = 0;
      burst_left = 0;
      stalls = 0;
    end else begin
      if (es && stalls < 65535) stalls++;
      if ((eh && hw) || (ec && cw)) ref_mem[ea] = eh ? hd : cd;
      hwait = (hr && !eh) ? ((hwait < SL) ? hwait + 1 : SL) : 0;
      if (burst_left > 0) begin
        if (eh && hl && burst_left > 1) burst_left--;
        else begin
          burst_left = 0;
          hwait = 0;
        end
      end else if (eh && hl && MB > 1) burst_left = MB - 1;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 8'h10, 8'h55, 1, 1, 1, 8'h11, 8'h66);
    chk("reset_no_write", mem[8'h10], ref_mem[8'h10]);
    for (int a = 8'h10; a <= 8'h13; a++) begin
      step(0, 0, 1, 0, 8'(a), 0, 0, 0, 0, 0, 0);
      chk("core_only_stall", last_stall, 0);
      chk("core_only_gnt", last_hg, 0);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 1, 0, 8'($urandom), 0, 1, 0, 0, 8'($urandom), 0);
      chk("starve_gnt", last_hg, (i % 5) == 4);
      chk("starve_stall", last_stall, (i % 5) == 4);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 1, 0, 8'($urandom), 0, 1, 0, 1, 8'($urandom), 0);
      chk("burst_gnt", last_hg, i >= 4 && i <= 11);
    end
    chk("burst_stall_ct", stall_ct, 8);
    step(0, 1, 1, 1, 8'h3F, 8'h11, 1, 1, 0, 8'h3F, 8'hA5);
    chk("halt_wr_gnt", last_hg, 1);
    chk("halt_wr_stall", last_stall, 0);
    step(0, 1, 1, 0, 8'h3F, 0, 1, 0, 0, 8'h3F, 0);
    chk("halt_rd_gnt", last_hg, 1);
    chk("halt_rdata", last_hrd, 8'hA5);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 8'h01, 0, 1, 1, 1, 8'h30, 8'h77);
    step(1, 0, 1, 1, 8'h31, 8'h88, 1, 1, 1, 8'h31, 8'h99);
    chk("rst_burst_stall_ct", stall_ct, 0);
    chk("rst_burst_no_write", mem[8'h31], ref_mem[8'h31]);
    step(0, 0, 1, 0, 8'h02, 0, 1, 1, 1, 8'h32, 8'h44);
    chk("rst_burst_core_wins", last_stall, 0);
    chk("rst_burst_host_waits", last_hg, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'h05, 0, 1, 0, 0, 8'h06, 0);
    step(0, 0, 1, 1, 8'h20, 8'h11, 1, 1, 0, 8'h20, 8'h22);
    chk("collide_stall", last_stall, 1);
    chk("collide_mem", mem[8'h20], 8'h22);
    step(0, 0, 1, 1, 8'h20, 8'h11, 0, 0, 0, 0, 0);
    chk("retry_mem", mem[8'h20], 8'h11);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom),
           1'($urandom), $urandom_range(0, 3) != 0, 8'($urandom_range(0, 15)), 8'($urandom));
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
